counter_seq_ctrl: RTL and testbench
===================================

# counter_seq_ctrl

Sequencing controller for the team's 4-bit loadable up/down counter, the one with the load > up > down priority. On a start request it loads the counter with a start value, then steps it toward a stop value for a programmed number of passes. The passes are one-directional (up or down, with wrap-around) or bouncing between the two values. It sits beside the counter and drives the counter's load/up/down/in pins. It reads the counter's output back as feedback.

## Interface
- WIDTH, 4: counter data width.
- REP_W, 3: width of pass-count fields.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin sequence; sampled only in IDLE.
- abort  in  1  terminate sequence; highest priority after reset.
- hold  in  1  pause stepping (see Configuration).
- start_val  in  WIDTH  value loaded at the start of each pass/sequence.
- stop_val  in  WIDTH  target value.
- mode  in  2  00 up, 01 down, 10 bounce, 11 treated as up.
- reps  in  REP_W  number of passes; 0 treated as 1.
- cnt_q  in  WIDTH  counter output, fed back.
- ld  out  1  to counter load.
- ld_val  out  WIDTH  to counter in; registered copy of start_val.
- up  out  1  to counter up.
- dn  out  1  to counter down.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- pass_cnt  out  REP_W  passes completed in the current sequence.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - On start=1 and abort=0: capture start_val, stop_val, mode and reps (0→1); clear pass_cnt.
  - Set target=stop_val and dir=down if mode=01, else up.
  - Go to LOAD.
- **LOAD**
  - ld=1 and ld_val=captured start_val for exactly one cycle; then go to RUN.
- **RUN**
  - If cnt_q≠target: assert up (dir=up) or dn (dir=down) combinationally.
  - If cnt_q==target: up=dn=0 and pass_cnt increments. Then:
    - pass_cnt+1==reps → DONE.
    - Otherwise, mode up/down → LOAD.
    - Otherwise, mode bounce → stay in RUN, invert dir, swap target between start_val and stop_val. There is no reload.
- **DONE**
  - done=1 for one cycle; then IDLE.
  - pass_cnt holds its final value until the next accepted start.
- **Control outputs**
  - ld, up and dn are mutually exclusive; never more than one is high in a cycle.
- **Wrap-around**
  - Counting is modulo 2^WIDTH.
  - Up mode with stop_val<start_val counts through 15→0.
  - Down mode with stop_val>start_val counts through 0→15.
  - Bounce legs wrap the same way.
- **Zero-length pass**
  - start_val==stop_val: each pass completes on its first RUN cycle with no steps issued.
- **Ignored or overriding inputs**
  - start while busy is ignored.
  - abort=1 in LOAD, RUN or DONE → IDLE next edge. No done pulse; ld/up/dn drop in that cycle's next state.
  - abort and start together in IDLE → remain in IDLE.
- **Input capture**
  - Captured inputs are immune to changes after start is accepted.

## Timing
- **Reset values**
  - ld=0, up=0, dn=0, ld_val=0, busy=0, done=0, pass_cnt=0; state IDLE.
  - Reset asserted mid-sequence forces these values immediately, with no done.
- **Latency**
  - start sampled at edge E → LOAD in cycle E+1, ld high → counter holds start_val in cycle E+2 (first RUN cycle).
- **Pass length**
  - A pass of N steps occupies N+1 RUN cycles: N stepping cycles plus one match cycle.
  - An up/down mode repeat costs one extra LOAD cycle per pass.
- **Done**
  - done is asserted in the cycle after the final match cycle.
- **Output type**
  - ld, ld_val, busy, done and pass_cnt are registered or state-decoded.
  - up/dn depend combinationally on cnt_q in RUN.

## Configuration
- COUNTER_SEQ_HOLD_EN
  - **Defined:** hold=1 in RUN forces up=dn=0 and freezes state, dir, target and pass_cnt. The match check is suppressed while held. Hold has no effect in IDLE, LOAD or DONE.
  - **Undefined:** the hold port exists but is ignored; there is no hold logic.

## Test plan
- **Up pass, no wrap:** mode=00, start_val=2, stop_val=5, reps=1.
  - ld in cycle E+1; up high exactly 3 cycles (cnt_q 2,3,4).
  - Match at cnt_q=5; done at E+6; pass_cnt=1.
- **Up pass with wrap:** mode=00, start_val=14, stop_val=1.
  - up high 3 cycles (14,15,0); match at 1; done pulse.
- **Bounce:** mode=10, start_val=3, stop_val=6, reps=3.
  - up 3 cycles, then dn 3 cycles, then up 3 cycles; ld only once.
  - pass_cnt steps 1,2,3; single done.
- **Zero-length passes:** mode=01, start_val=stop_val=5, reps=2.
  - Two ld pulses, no up/dn, done; pass_cnt=2.
- **Abort and reset:** abort at the second RUN cycle of test 1 → IDLE next edge, no done, busy=0.
  - Repeat with reset pulsed instead → all outputs 0 immediately.
  - start asserted during busy is ignored.
- **Hold (COUNTER_SEQ_HOLD_EN defined):** hold=1 for 4 cycles during test 1 RUN.
  - up low while held; cnt_q frozen; done delayed by exactly 4 cycles.
  - Without the macro, timing is identical to test 1.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a 4-bit load>up>down counter: load, step to target, repeat or bounce.
// Optional hold-in-RUN support is enabled by defining COUNTER_SEQ_HOLD_EN.
module counter_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned REP_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] stop_val,
    input  logic [1:0]       mode,
    input  logic [REP_W-1:0] reps,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             ld,
    output logic [WIDTH-1:0] ld_val,
    output logic             up,
    output logic             dn,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] pass_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   start_q;
    logic [WIDTH-1:0]   stop_q;
    logic [REP_W-1:0]   reps_q;
    logic               bounce_q;
    logic               dir_dn;
    logic               leg;        // 0: heading to stop value, 1: heading back to start value
    logic [WIDTH-1:0]   target_c;
    logic               match_c;
    logic               held_c;
    logic [REP_W-1:0]   pass_next_c;

`ifdef COUNTER_SEQ_HOLD_EN
    assign held_c = hold && (state == RUN);
`else
    logic unused_hold;
    assign unused_hold = hold;
    assign held_c      = 1'b0;
`endif

    assign target_c    = leg ? start_q : stop_q;
    assign match_c     = (cnt_q == target_c);
    assign pass_next_c = pass_cnt + REP_W'(1);

    // Control strobes decoded directly from the state register
    assign ld     = (state == LOAD);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign ld_val = start_q;

    // Step requests follow the counter feedback within the RUN cycle
    always_comb begin
        up = 1'b0;
        dn = 1'b0;
        if (state == RUN && !held_c && !match_c) begin
            up = !dir_dn;
            dn = dir_dn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            start_q  <= '0;
            stop_q   <= '0;
            reps_q   <= '0;
            bounce_q <= 1'b0;
            dir_dn   <= 1'b0;
            leg      <= 1'b0;
            pass_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        start_q  <= start_val;
                        stop_q   <= stop_val;
                        reps_q   <= (reps == '0) ? REP_W'(1) : reps;
                        bounce_q <= (mode == 2'b10);
                        dir_dn   <= (mode == 2'b01);
                        leg      <= 1'b0;
                        pass_cnt <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    state <= abort ? IDLE : RUN;
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (!held_c && match_c) begin
                        pass_cnt <= pass_next_c;
                        if (pass_next_c == reps_q) begin
                            state <= DONE;
                        end else if (bounce_q) begin
                            dir_dn <= !dir_dn;
                            leg    <= !leg;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural load>up>down counter in the loop.
// Hold expectations depend on COUNTER_SEQ_HOLD_EN.
module tb_counter_seq_ctrl;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned REP_W = 3;
    localparam int MAXC = 40;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic             hold;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] stop_val;
    logic [1:0]       mode;
    logic [REP_W-1:0] reps;
    logic [WIDTH-1:0] cnt_q;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             up;
    logic             dn;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] pass_cnt;

    int checks   = 0;
    int failures = 0;

    int n_ld, n_up, n_dn, n_done, n_multi;
    int done_cyc, first_dn, idle_cyc, cnt_at_done, pc_at_done, ldval_seen, rst_snap;
    int pc_tr [MAXC+1];

    always #5 clk = ~clk;

    counter_seq_ctrl #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .hold      (hold),
        .start_val (start_val),
        .stop_val  (stop_val),
        .mode      (mode),
        .reps      (reps),
        .cnt_q     (cnt_q),
        .ld        (ld),
        .ld_val    (ld_val),
        .up        (up),
        .dn        (dn),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt)
    );

    // Loadable up/down counter being sequenced
    always @(posedge clk or posedge reset) begin
        if (reset)   cnt_q <= '0;
        else if (ld) cnt_q <= ld_val;
        else if (up) cnt_q <= cnt_q + 4'd1;
        else if (dn) cnt_q <= cnt_q - 4'd1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int out_vec();
        return int'({ld, up, dn, busy, done, pass_cnt, ld_val});
    endfunction

    // Start a sequence at edge E, then observe cycles E+1..E+MAXC
    task automatic run_seq(input logic [3:0] sv, input logic [3:0] pv, input logic [1:0] m,
                           input logic [2:0] r, input int abort_at, input int hold_from,
                           input int hold_len, input int restart_at, input int reset_at);
        n_ld = 0; n_up = 0; n_dn = 0; n_done = 0; n_multi = 0;
        done_cyc = -1; first_dn = -1; idle_cyc = -1; cnt_at_done = -1;
        pc_at_done = -1; ldval_seen = -1; rst_snap = -1;
        @(negedge clk);
        start_val = sv; stop_val = pv; mode = m; reps = r;
        start = 1'b1; abort = 1'b0; hold = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= MAXC; c++) begin
            @(negedge clk);
            reset     = 1'b0;
            start_val = ~sv;
            stop_val  = ~pv;
            mode      = ~m;
            reps      = ~r;
            start     = (c == restart_at);
            abort     = (c == abort_at);
            hold      = (c >= hold_from) && (c < hold_from + hold_len);
            #1;
            if (ld) begin
                n_ld++;
                ldval_seen = int'(ld_val);
            end
            if (up) n_up++;
            if (dn) n_dn++;
            if ((int'(ld) + int'(up) + int'(dn)) > 1) n_multi++;
            if (dn && first_dn < 0) first_dn = c;
            if (!busy && idle_cyc < 0) idle_cyc = c;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc    = c;
                    cnt_at_done = int'(cnt_q);
                    pc_at_done  = int'(pass_cnt);
                end
            end
            pc_tr[c] = int'(pass_cnt);
            if (c == reset_at) begin
                reset = 1'b1;
                #1;
                rst_snap = out_vec();
            end
        end
        start = 1'b0; abort = 1'b0; hold = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
        start_val = '0; stop_val = '0; mode = '0; reps = '0;
        #12;
        check("reset_outputs", out_vec(), 0);
        @(negedge clk);
        reset = 1'b0;

        // Up pass, no wrap
        run_seq(4'd2, 4'd5, 2'b00, 3'd1, 0, 0, 0, 0, 0);
        check("t1_ld_count", n_ld, 1);
        check("t1_ld_val", ldval_seen, 2);
        check("t1_up_count", n_up, 3);
        check("t1_dn_count", n_dn, 0);
        check("t1_done_cycle", done_cyc, 6);
        check("t1_done_count", n_done, 1);
        check("t1_cnt_at_done", cnt_at_done, 5);
        check("t1_pass_cnt", pc_at_done, 1);
        check("t1_idle_cycle", idle_cyc, 7);
        check("t1_pass_cnt_held", pc_tr[MAXC], 1);
        check("t1_exclusive", n_multi, 0);

        // Up pass with wrap 14,15,0 -> 1
        run_seq(4'd14, 4'd1, 2'b00, 3'd1, 0, 0, 0, 0, 0);
        check("t2_up_count", n_up, 3);
        check("t2_done_cycle", done_cyc, 6);
        check("t2_cnt_at_done", cnt_at_done, 1);

        // Bounce 3 <-> 6, three passes
        run_seq(4'd3, 4'd6, 2'b10, 3'd3, 0, 0, 0, 0, 0);
        check("t3_ld_count", n_ld, 1);
        check("t3_up_count", n_up, 6);
        check("t3_dn_count", n_dn, 3);
        check("t3_first_dn", first_dn, 6);
        check("t3_pass_after_1", pc_tr[6], 1);
        check("t3_pass_after_2", pc_tr[10], 2);
        check("t3_done_cycle", done_cyc, 14);
        check("t3_pass_cnt", pc_at_done, 3);
        check("t3_done_count", n_done, 1);
        check("t3_exclusive", n_multi, 0);

        // Zero-length down passes
        run_seq(4'd5, 4'd5, 2'b01, 3'd2, 0, 0, 0, 0, 0);
        check("t4_ld_count", n_ld, 2);
        check("t4_step_count", n_up + n_dn, 0);
        check("t4_done_cycle", done_cyc, 5);
        check("t4_pass_cnt", pc_at_done, 2);

        // Up mode, two passes with reload
        run_seq(4'd2, 4'd5, 2'b00, 3'd2, 0, 0, 0, 0, 0);
        check("t5_ld_count", n_ld, 2);
        check("t5_up_count", n_up, 6);
        check("t5_done_cycle", done_cyc, 11);

        // reps=0 behaves as one pass
        run_seq(4'd2, 4'd5, 2'b00, 3'd0, 0, 0, 0, 0, 0);
        check("t6_done_cycle", done_cyc, 6);
        check("t6_pass_cnt", pc_at_done, 1);

        // Down with wrap 1,0,15 -> 14
        run_seq(4'd1, 4'd14, 2'b01, 3'd1, 0, 0, 0, 0, 0);
        check("t7_dn_count", n_dn, 3);
        check("t7_up_count", n_up, 0);
        check("t7_cnt_at_done", cnt_at_done, 14);

        // mode 11 counts up
        run_seq(4'd7, 4'd9, 2'b11, 3'd1, 0, 0, 0, 0, 0);
        check("t8_up_count", n_up, 2);
        check("t8_done_cycle", done_cyc, 5);

        // Abort in second RUN cycle
        run_seq(4'd2, 4'd5, 2'b00, 3'd1, 3, 0, 0, 0, 0);
        check("t9_idle_cycle", idle_cyc, 4);
        check("t9_done_count", n_done, 0);
        check("t9_up_count", n_up, 2);
        check("t9_pass_cnt", pc_tr[10], 0);

        // Start while busy is ignored
        run_seq(4'd2, 4'd5, 2'b00, 3'd1, 0, 0, 0, 3, 0);
        check("t10_ld_count", n_ld, 1);
        check("t10_ld_val", ldval_seen, 2);
        check("t10_done_cycle", done_cyc, 6);

        // Hold for four RUN cycles
        run_seq(4'd2, 4'd5, 2'b00, 3'd1, 0, 3, 4, 0, 0);
        check("t11_up_count", n_up, 3);
`ifdef COUNTER_SEQ_HOLD_EN
        check("t11_done_cycle", done_cyc, 10);
`else
        check("t11_done_cycle", done_cyc, 6);
`endif

        // Reset mid-bounce, after first pass
        run_seq(4'd3, 4'd6, 2'b10, 3'd3, 0, 0, 0, 0, 7);
        check("t12_pass_before_reset", pc_tr[7], 1);
        check("t12_reset_outputs", rst_snap, 0);
        check("t12_done_count", n_done, 0);
        check("t12_idle_cycle", idle_cyc, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
